// File: rtl/data_pipe_interconnect_nx.sv
// N-to-1 valid/ready stream mux feeding one downstream port through a 2-entry skid buffer.
// Define DPI_NX_LAST_EN to add s_last/m_last ports and packet-locked path switching.
module data_pipe_interconnect_nx #(
    parameter int DSIZE = 8,
    parameter int NUM   = 8,
    parameter int MODE  = 0,
    localparam int PW   = $clog2(NUM)
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 vld_sw,
    input  logic [PW-1:0]        sw,
    output logic [PW-1:0]        curr_path,
    input  logic [NUM-1:0]       s_valid,
    input  logic [NUM*DSIZE-1:0] s_data,
    output logic [NUM-1:0]       s_ready,
`ifdef DPI_NX_LAST_EN
    input  logic [NUM-1:0]       s_last,
    output logic                 m_last,
`endif
    output logic                 m_valid,
    output logic [DSIZE-1:0]     m_data,
    input  logic                 m_ready,
    output logic [1:0]           occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [DSIZE-1:0] head, skid, in_data;
    logic             in_valid, in_ready, push, pop;
    logic             ready_en, switch_ok, path_chg, rr_found;
    logic [PW-1:0]    target, rr_path;
    logic [NUM-1:0]   s_ready_nxt;
    logic             locked;

    assign in_valid  = s_valid[curr_path];
    assign in_ready  = s_ready[curr_path];
    assign push      = in_valid & in_ready & clk_en;
    assign pop       = m_valid & m_ready & clk_en;
    assign ready_en  = (MODE != 0) || vld_sw;
    assign m_valid   = (state != EMPTY);
    assign m_data    = head;
    assign occupancy = state;

    always_comb begin
        in_data = '0;
        for (int k = 0; k < NUM; k++) begin
            if (PW'(k) == curr_path) in_data = s_data[k*DSIZE +: DSIZE];
        end
    end

`ifdef DPI_NX_LAST_EN
    logic head_last, skid_last, in_last;

    assign in_last = s_last[curr_path];
    assign m_last  = head_last;

    // Lock is held from the first beat of a packet until its last beat has been accepted.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            locked    <= 1'b0;
            head_last <= 1'b0;
            skid_last <= 1'b0;
        end else if (clk_en) begin
            if (push) locked <= !in_last;
            case (state)
                EMPTY: if (push) head_last <= in_last;
                ONE: begin
                    if (push && pop) head_last <= in_last;
                    else if (push)   skid_last <= in_last;
                end
                TWO: if (pop) head_last <= skid_last;
                default: ;
            endcase
        end
    end
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (pop && !push) state_nxt = EMPTY;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Round-robin search starts just above the current path and wraps back onto it.
    always_comb begin
        rr_found = 1'b0;
        rr_path  = curr_path;
        for (int k = 1; k <= NUM; k++) begin
            if (!rr_found && s_valid[PW'((int'(curr_path) + k) % NUM)]) begin
                rr_found = 1'b1;
                rr_path  = PW'((int'(curr_path) + k) % NUM);
            end
        end
    end

    // A requesting round-robin channel that has not yet seen its ready keeps the grant,
    // otherwise the path would rotate forever while ready lags by a cycle.
    always_comb begin
        switch_ok = clk_en && (state_nxt == EMPTY) && !push && !locked;
        if (MODE == 0) target = (int'(sw) < NUM) ? sw : curr_path;
        else           target = (in_valid && !in_ready) ? curr_path : rr_path;
        path_chg = switch_ok && (target != curr_path);
    end

    always_comb begin
        s_ready_nxt = '0;
        if (!clk_en) begin
            s_ready_nxt = ready_en ? s_ready : '0;
        end else if (!path_chg && (state_nxt != TWO) && ready_en) begin
            s_ready_nxt[curr_path] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            head      <= '0;
            skid      <= '0;
            curr_path <= '0;
            s_ready   <= '0;
        end else begin
            s_ready <= s_ready_nxt;
            if (clk_en) begin
                state <= state_nxt;
                if (path_chg) curr_path <= target;
                case (state)
                    EMPTY: if (push) head <= in_data;
                    ONE: begin
                        if (push && pop) head <= in_data;
                        else if (push)   skid <= in_data;
                    end
                    TWO: if (pop) head <= skid;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_pipe_interconnect_nx.sv
// Directed self-checking bench for data_pipe_interconnect_nx: one MODE 0 and one MODE 1 instance
// share stimulus; a FIFO scoreboard follows whichever instance is being watched.
module tb_data_pipe_interconnect_nx;
    localparam int DSIZE = 8;
    localparam int NUM   = 8;

    logic        clock = 1'b0;
    logic        rst, clk_en, vld_sw, m_ready;
    logic [2:0]  sw;
    logic [7:0]  s_valid;
    logic [63:0] s_data;
    logic [2:0]  cp0, cp1;
    logic [7:0]  rdy0, rdy1;
    logic        mv0, mv1;
    logic [7:0]  md0, md1;
    logic [1:0]  occ0, occ1;
`ifdef DPI_NX_LAST_EN
    logic [7:0]  s_last;
    logic        ml0, ml1;
`endif

    always #5 clock = ~clock;

    data_pipe_interconnect_nx #(.DSIZE(DSIZE), .NUM(NUM), .MODE(0)) dut0 (
        .clock(clock), .rst(rst), .clk_en(clk_en), .vld_sw(vld_sw), .sw(sw),
        .curr_path(cp0), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy0),
`ifdef DPI_NX_LAST_EN
        .s_last(s_last), .m_last(ml0),
`endif
        .m_valid(mv0), .m_data(md0), .m_ready(m_ready), .occupancy(occ0)
    );

    data_pipe_interconnect_nx #(.DSIZE(DSIZE), .NUM(NUM), .MODE(1)) dut1 (
        .clock(clock), .rst(rst), .clk_en(clk_en), .vld_sw(vld_sw), .sw(sw),
        .curr_path(cp1), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy1),
`ifdef DPI_NX_LAST_EN
        .s_last(s_last), .m_last(ml1),
`endif
        .m_valid(mv1), .m_data(md1), .m_ready(m_ready), .occupancy(occ1)
    );

    logic       watch;
    logic [2:0] wcp;
    logic [7:0] wrdy, wmd;
    logic       wmv;
    logic [1:0] wocc;
    assign wcp  = watch ? cp1  : cp0;
    assign wrdy = watch ? rdy1 : rdy0;
    assign wmv  = watch ? mv1  : mv0;
    assign wmd  = watch ? md1  : md0;
    assign wocc = watch ? occ1 : occ0;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         pushes, pops, cycles, base;
    logic [7:0] nxt[NUM];
    logic [7:0] sb[$];
    int         gq[$];
    logic [7:0] drop;
    int         prev;
    int         exp_g[5] = '{0, 2, 5, 7, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict handshakes from the pre-edge view, then update the scoreboard model.
    task automatic tick();
        int         c;
        logic       p, q;
        logic [7:0] d;
        for (int k = 0; k < NUM; k++) s_data[k*DSIZE +: DSIZE] = nxt[k];
        c = int'(wcp);
        p = s_valid[c] & wrdy[c] & clk_en;
        q = wmv & m_ready & clk_en;
        d = wmd;
        @(negedge clock);
        cycles++;
        if (q) begin
            pops++;
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("[TB] FAIL pop_underflow: observed empty scoreboard, expected a buffered beat");
            end
            if (sb.size() != 0) chk("pop_data", d, sb.pop_front());
        end
        if (p) begin
            sb.push_back(nxt[c]);
            gq.push_back(c);
            nxt[c] = nxt[c] + 8'd1;
            pushes++;
        end
        chk("occupancy", wocc, sb.size());
        chk("m_valid", wmv, sb.size() != 0);
        if (sb.size() != 0) chk("m_data", wmd, sb[0]);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; vld_sw = 1'b1; sw = 3'd3;
        s_valid = 8'h00; m_ready = 1'b1; watch = 1'b0;
        pushes = 0; pops = 0; cycles = 0; drop = 8'h00; prev = 0;
        for (int c = 0; c < NUM; c++) nxt[c] = 8'(c * 16);
        nxt[3] = 8'h10;
        for (int k = 0; k < NUM; k++) s_data[k*DSIZE +: DSIZE] = nxt[k];
`ifdef DPI_NX_LAST_EN
        s_last = 8'h00;
`endif
        repeat (2) @(negedge clock);

        chk("rst_curr_path", cp0, 0);
        chk("rst_s_ready", rdy0, 8'h00);
        chk("rst_m_valid", mv0, 0);
        chk("rst_m_data", md0, 8'h00);
        chk("rst_occupancy", occ0, 0);
        chk("rst_s_ready_rr", rdy1, 8'h00);
        rst = 1'b0;

        // Stream of 16 beats on channel 3
        s_valid = 8'h08;
        tick();
        chk("t1_path", cp0, 3);
        chk("t1_ready_gap", rdy0, 8'h00);
        tick();
        chk("t1_ready", rdy0, 8'h08);
        cycles = 0;
        for (int i = 0; i < 40 && pops < 16; i++) begin
            if (pushes == 16) s_valid = 8'h00;
            tick();
            if (i == 0) chk("t1_first_beat", md0, 8'h10);
        end
        chk("t1_cycles", cycles, 17);
        chk("t1_pushes", pushes, 16);
        chk("t1_ready_idle", rdy0, 8'h08);

        // Backpressure for three cycles
        s_valid = 8'h08;
        tick();
        tick();
        m_ready = 1'b0;
        tick();
        chk("t2_full", occ0, 2);
        chk("t2_ready_drop", rdy0, 8'h00);
        tick();
        tick();
        chk("t2_hold_ready", rdy0, 8'h00);
        chk("t2_head", md0, 8'h21);
        m_ready = 1'b1;
        tick();
        chk("t2_ready_back", rdy0, 8'h08);
        m_ready = 1'b0;
        tick();
        chk("t2_refill", occ0, 2);

        // Switch request while full is deferred until the buffer drains
        sw = 3'd5;
        s_valid = 8'h20;
        tick();
        chk("t3_hold_full", cp0, 3);
        m_ready = 1'b1;
        tick();
        chk("t3_hold_one", cp0, 3);
        tick();
        chk("t3_switched", cp0, 5);
        chk("t3_ready_gap", rdy0, 8'h00);
        tick();
        chk("t3_new_ready", rdy0, 8'h20);
        tick();
        chk("t3_new_data", md0, 8'h50);

        // clk_en toggling: only enabled cycles move data
        base = pushes;
        for (int i = 0; i < 24; i++) begin
            clk_en = (i % 2 == 1);
            tick();
        end
        chk("t5_pushes", pushes - base, 12);
        chk("t5_ready_held", rdy0, 8'h20);
        clk_en = 1'b1;
        s_valid = 8'h00;
        tick();
        clk_en = 1'b0;
        vld_sw = 1'b0;
        tick();
        chk("t5_vld_sw_gate", rdy0, 8'h00);
        clk_en = 1'b1;
        vld_sw = 1'b1;
        tick();
        chk("t5_ready_restore", rdy0, 8'h20);

        // Reset while two beats are buffered
        s_valid = 8'h20;
        m_ready = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_occ", occ0, 0);
        chk("rst_mid_valid", mv0, 0);
        chk("rst_mid_path", cp0, 0);
        sb.delete();

        // Round-robin with single-beat sources on channels 0,2,5,7
        watch = 1'b1;
        for (int c = 0; c < NUM; c++) nxt[c] = 8'hA0 + 8'(c);
        m_ready = 1'b1;
        s_valid = 8'hA5;
        gq.delete();
        @(negedge clock);
        rst = 1'b0;
        tick();
        chk("t4_first_ready", rdy1, 8'h01);
        chk("t4_first_path", cp1, 0);
        drop = 8'h00;
        for (int i = 0; i < 40 && gq.size() < 5; i++) begin
            s_valid = 8'hA5 & ~drop;
            prev = gq.size();
            tick();
            drop = (gq.size() > prev) ? (8'h01 << gq[gq.size()-1]) : 8'h00;
        end
        chk("t4_grant_count", gq.size(), 5);
        for (int k = 0; k < 5 && k < gq.size(); k++) chk("t4_grant_order", gq[k], exp_g[k]);
        s_valid = 8'h00;
        tick();
        tick();

`ifdef DPI_NX_LAST_EN
        // Packet lock: channel 1 packet of four beats, switch request after beat two
        watch = 1'b0;
        rst = 1'b1;
        sb.delete();
        sw = 3'd1;
        nxt[1] = 8'h60;
        nxt[2] = 8'h70;
        s_valid = 8'h02;
        @(negedge clock);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_beat1_last", ml0, 0);
        tick();
        sw = 3'd2;
        s_valid = 8'h04;
        tick();
        chk("t6_locked_a", cp0, 1);
        tick();
        chk("t6_locked_b", cp0, 1);
        chk("t6_locked_ready", rdy0, 8'h02);
        s_valid = 8'h06;
        tick();
        chk("t6_beat3_last", ml0, 0);
        s_last = 8'h02;
        tick();
        chk("t6_beat4_last", ml0, 1);
        chk("t6_rr_last", ml1, 0);
        s_last = 8'h00;
        s_valid = 8'h04;
        tick();
        chk("t6_switched", cp0, 2);
        tick();
        chk("t6_new_ready", rdy0, 8'h04);
        tick();
        s_valid = 8'h00;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
